// File: rtl/rveval_soc.sv
// RVEVAL-2 SoC shell: 8N1 UART receiver echoing through a FIFO to the transmitter,
// sticky status flags and counters on gpio_o, and a PDM density meter.
module rveval_soc #(
    parameter int unsigned CLKS_PER_BIT    = 50,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned PDM_WINDOW      = 256,
    parameter int unsigned TX_CLKS_PER_BIT = CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_pdm,
    input  logic        pdm_input,
    input  logic [31:0] gpio_i,
    output logic [31:0] gpio_o,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int unsigned RCW = $clog2(CLKS_PER_BIT);
    localparam int unsigned TCW = $clog2(TX_CLKS_PER_BIT);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned SW  = $clog2(PDM_WINDOW);
    localparam int unsigned PW  = ($clog2(PDM_WINDOW + 1) > 9) ? $clog2(PDM_WINDOW + 1) : 9;

    localparam logic [RCW-1:0] RX_LAST  = RCW'(CLKS_PER_BIT - 1);
    localparam logic [RCW-1:0] RX_HALF  = RCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TCW-1:0] TX_LAST  = TCW'(TX_CLKS_PER_BIT - 1);
    localparam logic [SW-1:0]  PDM_LAST = SW'(PDM_WINDOW - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    rx_state_e      rx_state;
    logic           rx_meta, rx_sync, rx_prev;
    logic [RCW-1:0] rx_cnt;
    logic [2:0]     rx_bit;
    logic [7:0]     rx_shift;
    logic [7:0]     last_byte;
    logic [7:0]     rx_count;
    logic           rx_done, push, ferr_set, ovf_set;
    logic           ovf_flag, ferr_flag;

    tx_state_e      tx_state;
    logic [TCW-1:0] tx_cnt;
    logic [2:0]     tx_bit;
    logic [7:0]     tx_shift;
    logic           pop;

    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           fifo_full, fifo_empty, fifo_wr;
    logic [7:0]     fifo_head;

    logic           pclk_meta, pclk_sync, pclk_prev, pdat_meta, pdat_sync, pdm_edge;
    logic [SW-1:0]  samp_cnt;
    logic [PW-1:0]  ones_cnt, ones_next;
    logic [7:0]     pdm_sat, pdm_level;

    logic           unused_gpio;
    assign unused_gpio = ^gpio_i[31:1];

    // ---------------- UART receiver ----------------
    assign rx_done  = (rx_state == RxStop) && (rx_cnt == RX_LAST);
    assign push     = rx_done && rx_sync;
    assign ferr_set = rx_done && !rx_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= RxIdle;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            last_byte <= '0;
            rx_count  <= '0;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            case (rx_state)
                RxIdle: begin
                    if (!rx_sync && rx_prev) begin
                        rx_state <= RxStart;
                        rx_cnt   <= '0;
                    end
                end
                RxStart: begin
                    if (rx_cnt == RX_HALF) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RxIdle : RxData;
                    end else begin
                        rx_cnt <= rx_cnt + RCW'(1);
                    end
                end
                RxData: begin
                    if (rx_cnt == RX_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RxStop;
                    end else begin
                        rx_cnt <= rx_cnt + RCW'(1);
                    end
                end
                RxStop: begin
                    if (rx_cnt == RX_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RxIdle;
                        if (rx_sync) begin
                            last_byte <= rx_shift;
                            rx_count  <= rx_count + 8'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + RCW'(1);
                    end
                end
                default: rx_state <= RxIdle;
            endcase
        end
    end

    // ---------------- Echo FIFO ----------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign fifo_wr    = push && (!fifo_full || pop);
    assign ovf_set    = push && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_flag  <= 1'b0;
            ferr_flag <= 1'b0;
        end else begin
            ovf_flag  <= ovf_set  | (ovf_flag  & ~gpio_i[0]);
            ferr_flag <= ferr_set | (ferr_flag & ~gpio_i[0]);
        end
    end

    // ---------------- UART transmitter ----------------
    // Popping at the end of the stop bit chains frames with no idle gap.
    assign pop = !fifo_empty &&
                 ((tx_state == TxIdle) || ((tx_state == TxStop) && (tx_cnt == TX_LAST)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TxIdle;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TxIdle: begin
                    if (pop) begin
                        tx_shift <= fifo_head;
                        uart_tx  <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= TxStart;
                    end
                end
                TxStart: begin
                    if (tx_cnt == TX_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_tx  <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_state <= TxData;
                    end else begin
                        tx_cnt <= tx_cnt + TCW'(1);
                    end
                end
                TxData: begin
                    if (tx_cnt == TX_LAST) begin
                        tx_cnt <= '0;
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= TxStop;
                        end else begin
                            uart_tx  <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + TCW'(1);
                    end
                end
                TxStop: begin
                    if (tx_cnt == TX_LAST) begin
                        tx_cnt <= '0;
                        if (pop) begin
                            tx_shift <= fifo_head;
                            uart_tx  <= 1'b0;
                            tx_state <= TxStart;
                        end else begin
                            tx_state <= TxIdle;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + TCW'(1);
                    end
                end
                default: tx_state <= TxIdle;
            endcase
        end
    end

    // ---------------- PDM density meter ----------------
    assign pdm_edge  = pclk_sync && !pclk_prev;
    assign ones_next = ones_cnt + PW'(pdat_sync);
    assign pdm_sat   = (ones_next > PW'(255)) ? 8'hFF : ones_next[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pclk_meta <= 1'b0;
            pclk_sync <= 1'b0;
            pclk_prev <= 1'b0;
            pdat_meta <= 1'b0;
            pdat_sync <= 1'b0;
            samp_cnt  <= '0;
            ones_cnt  <= '0;
            pdm_level <= '0;
        end else begin
            pclk_meta <= clk_pdm;
            pclk_sync <= pclk_meta;
            pclk_prev <= pclk_sync;
            pdat_meta <= pdm_input;
            pdat_sync <= pdat_meta;
            if (pdm_edge) begin
                if (samp_cnt == PDM_LAST) begin
                    pdm_level <= pdm_sat;
                    samp_cnt  <= '0;
                    ones_cnt  <= '0;
                end else begin
                    samp_cnt <= samp_cnt + SW'(1);
                    ones_cnt <= ones_next;
                end
            end
        end
    end

    assign gpio_o = {pdm_level, 6'b0, ferr_flag, ovf_flag, rx_count, last_byte};

endmodule

// File: tb/tb_rveval_soc.sv
// Directed-plus-random bench for rveval_soc: UART echo, counters, sticky flags, PDM meter.
module tb_rveval_soc;

    localparam int unsigned CPB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_pdm, pdm_input, uart_rx, uart_rx_s;
    logic [31:0] gpio_i, gpio_o, gpio_s;
    logic        uart_tx, uart_tx_s;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;

    logic [7:0]  tx_got[$];
    logic [7:0]  exp_q[$];
    int unsigned tx_fall_cyc = 0;
    int unsigned tx_bad = 0;

    logic [7:0]  m_last, m_count, m_pdm;

    rveval_soc #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .PDM_WINDOW(256)) dut (
        .clk(clk), .reset(reset), .clk_pdm(clk_pdm), .pdm_input(pdm_input),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    // Transmitter at half the receive rate, so the FIFO must overflow.
    rveval_soc #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .PDM_WINDOW(256),
                 .TX_CLKS_PER_BIT(2 * CPB)) dut_slow (
        .clk(clk), .reset(reset), .clk_pdm(clk_pdm), .pdm_input(pdm_input),
        .gpio_i(gpio_i), .gpio_o(gpio_s), .uart_tx(uart_tx_s), .uart_rx(uart_rx_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: observed no end of run, required $finish before 900 us");
        $fatal(1);
    end

    // Serial decoder on uart_tx: samples each bit near its centre.
    initial begin : tx_monitor
        logic [7:0] d;
        logic       st_ok;
        forever begin
            @(negedge uart_tx);
            @(negedge clk);
            tx_fall_cyc = cyc;
            repeat (CPB / 2 - 1) @(negedge clk);
            st_ok = (uart_tx == 1'b0);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                d[k] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            if (!st_ok || uart_tx !== 1'b1) tx_bad++;
            tx_got.push_back(d);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit slow, input logic v);
        if (slow) uart_rx_s = v;
        else      uart_rx   = v;
    endtask

    // Called at a negedge; returns at the negedge ending the stop bit.
    task automatic send_frame(input bit slow, input logic [7:0] b, input logic stop_bit,
                              output int unsigned stop_cyc);
        drive(slow, 1'b0);
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            drive(slow, b[k]);
            repeat (CPB) @(negedge clk);
        end
        drive(slow, stop_bit);
        stop_cyc = cyc;
        repeat (CPB) @(negedge clk);
        drive(slow, 1'b1);
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_last  = b;
        m_count = m_count + 8'd1;
        exp_q.push_back(b);
    endtask

    task automatic flush();
        repeat (12 * CPB) @(negedge clk);
        tx_got.delete();
        exp_q.delete();
        tx_bad = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        m_last  = 8'h00;
        m_count = 8'h00;
        m_pdm   = 8'h00;
        flush();
    endtask

    task automatic check_echoes(input string tag, input int budget);
        int n;
        n = exp_q.size();
        for (int i = 0; i < budget && tx_got.size() < n; i++) @(negedge clk);
        chk({tag, "_count"}, tx_got.size(), n);
        while (exp_q.size() > 0 && tx_got.size() > 0)
            chk({tag, "_byte"}, tx_got.pop_front(), exp_q.pop_front());
        chk({tag, "_framing"}, tx_bad, 0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        gpio_i[0] = 1'b1;
        @(negedge clk);
        gpio_i[0] = 1'b0;
        @(negedge clk);
    endtask

    // mode: 0 alternating, 1 all ones, 2 all zeros, 3 random, 4 mostly ones
    task automatic pdm_window(input int mode);
        logic bits [256];
        int   sum;
        sum = 0;
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0:       bits[i] = (i % 2 == 0);
                1:       bits[i] = 1'b1;
                2:       bits[i] = 1'b0;
                3:       bits[i] = 1'($urandom_range(0, 1));
                default: bits[i] = ($urandom_range(0, 99) < 97);
            endcase
            sum += int'(bits[i]);
        end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            clk_pdm   = 1'b1;
            pdm_input = bits[i];
            @(negedge clk);
            clk_pdm = 1'b0;
            if (i == 254) begin
                repeat (5) @(negedge clk);
                chk("pdm_hold_255", gpio_o[31:24], m_pdm);
            end
        end
        repeat (5) @(negedge clk);
        m_pdm = (sum > 255) ? 8'hFF : 8'(sum);
        chk($sformatf("pdm_mode%0d", mode), gpio_o[31:24], m_pdm);
    endtask

    initial begin : stim
        int unsigned sc;
        logic [7:0]  b;

        uart_rx = 1'b1; uart_rx_s = 1'b1; gpio_i = '0; clk_pdm = 1'b0; pdm_input = 1'b0;
        m_last = 8'h00; m_count = 8'h00; m_pdm = 8'h00;

        // Reset held 50 ns
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", uart_tx, 1'b1);
        chk("rst_gpio_o", gpio_o, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_uart_tx", uart_tx, 1'b1);
        chk("post_rst_gpio_o", gpio_o, 32'h0);

        // Single byte 'S' and echo latency
        send_frame(1'b0, 8'h53, 1'b1, sc);
        model_byte(8'h53);
        chk("S_last_byte", gpio_o[7:0], m_last);
        chk("S_rx_count", gpio_o[15:8], m_count);
        for (int i = 0; i < 20 * CPB && tx_got.size() < 1; i++) @(negedge clk);
        // Line-side mid-stop + 3 cycles synchronizer/edge latency + 4 cycles allowance
        chk("S_echo_latency_ok",
            32'((tx_fall_cyc >= sc + CPB / 2) && (tx_fall_cyc <= sc + CPB / 2 + 7)), 1);
        check_echoes("S_echo", 20 * CPB);

        // 300 back-to-back bytes
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_frame(1'b0, 8'(i), 1'b1, sc);
            model_byte(8'(i));
        end
        chk("burst_rx_count", gpio_o[15:8], m_count);
        chk("burst_last_byte", gpio_o[7:0], m_last);
        check_echoes("burst_echo", 40 * CPB);
        chk("burst_no_overflow", gpio_o[16], 1'b0);

        // Random bytes with random inter-frame gaps
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            send_frame(1'b0, b, 1'b1, sc);
            model_byte(b);
            repeat ($urandom_range(0, 3 * CPB)) @(negedge clk);
        end
        chk("rand_rx_count", gpio_o[15:8], m_count);
        chk("rand_last_byte", gpio_o[7:0], m_last);
        check_echoes("rand_echo", 40 * CPB);

        // Framing error: stop bit 0
        b = 8'($urandom);
        send_frame(1'b0, b, 1'b0, sc);
        repeat (2 * CPB) @(negedge clk);
        chk("ferr_flag", gpio_o[17], 1'b1);
        chk("ferr_rx_count", gpio_o[15:8], m_count);
        chk("ferr_last_byte", gpio_o[7:0], m_last);
        chk("ferr_reserved", gpio_o[23:18], 6'h0);
        repeat (12 * CPB) @(negedge clk);
        chk("ferr_no_echo", tx_got.size(), 0);
        pulse_clear();
        chk("ferr_cleared", gpio_o[17], 1'b0);

        // Short low glitch: start bit fails the half-bit re-check
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("glitch_rx_count", gpio_o[15:8], m_count);
        chk("glitch_no_echo", tx_got.size(), 0);

        // Reset mid-frame on both RX and TX
        do_reset();
        send_frame(1'b0, 8'h5A, 1'b1, sc);
        fork
            send_frame(1'b0, 8'hFF, 1'b1, sc);
            begin
                repeat (3 * CPB) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                chk("midrst_uart_tx", uart_tx, 1'b1);
                chk("midrst_gpio_o", gpio_o, 32'h0);
                reset = 1'b0;
            end
        join
        repeat (4 * CPB) @(negedge clk);
        chk("midrst_partial_dropped", gpio_o, 32'h0);
        chk("midrst_tx_idle", uart_tx, 1'b1);
        flush();

        // Overflow on the slow-TX instance, then clear
        do_reset();
        for (int i = 0; i < 40; i++) send_frame(1'b1, 8'($urandom), 1'b1, sc);
        chk("ovf_rx_count", gpio_s[15:8], 8'd40);
        chk("ovf_flag_set", gpio_s[16], 1'b1);
        chk("ovf_main_untouched", gpio_o[16], 1'b0);
        pulse_clear();
        chk("ovf_flag_cleared", gpio_s[16], 1'b0);

        // PDM density windows
        do_reset();
        pdm_window(0);
        pdm_window(1);
        pdm_window(2);
        pdm_window(3);
        pdm_window(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rveval_soc.md
# rveval_soc

Minimal stand-alone SoC shell for the RVEVAL-2 evaluation board. It contains an 8N1 UART receiver and transmitter with a 16-entry echo FIFO, a status/GPIO output register, and a PDM density meter. It is the top-level block the board-level bench drives with a serial byte stream (SREC image) and a PDM bit stream. All logic runs in the single `clk` domain.

## Interface
Parameters:
- CLKS_PER_BIT, default 50: clk cycles per UART bit. 100 MHz / 50 = 2 Mbaud, i.e. 500 ns per bit.
- FIFO_DEPTH, default 16: echo FIFO entries. Must be a power of two.
- PDM_WINDOW, default 256: number of PDM samples per density measurement.

Ports:
- clk  in  1  system clock, 100 MHz. The only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- clk_pdm  in  1  PDM bit clock. Treated as data: synchronized and edge-detected in the clk domain, never used as a clock.
- pdm_input  in  1  PDM data bit.
- gpio_i  in  32  general inputs. Only bit 0 is used (clear sticky flags). Bits 31:1 are ignored.
- gpio_o  out  32  status register (layout below).
- uart_tx  out  1  serial output, idle high.
- uart_rx  in  1  serial input, idle high.

## Operation
- Reset: uart_tx=1; gpio_o=0; FIFO empty; all counters and flags 0.

UART RX:
- uart_rx passes through a 2-FF synchronizer.
- A falling edge while idle starts a frame.
- Start bit is re-checked at CLKS_PER_BIT/2. If it is high there, the receiver returns to idle with no byte.
- The 8 data bits are sampled LSB first, each at mid-bit.
- The stop bit is sampled at mid-bit:
  - Stop = 1: the byte is valid.
  - Stop = 0: set framing-error flag and discard the byte.
- States: IDLE, START, DATA, STOP.

On a valid byte:
- last_byte <= byte.
- rx_count <= rx_count+1 (mod 256).
- Push the byte to the FIFO if not full. If full, drop the byte and set the overflow flag.

UART TX:
- When idle and the FIFO is not empty, pop one byte and send it: start(0), 8 data LSB first, stop(1), each bit CLKS_PER_BIT cycles.
- States: IDLE, START, DATA, STOP.

PDM meter:
- clk_pdm and pdm_input each pass through a 2-FF synchronizer.
- On each detected rising edge of synchronized clk_pdm, sample synchronized pdm_input and increment the sample counter. If the sample is 1, increment the ones counter.
- After PDM_WINDOW samples, latch min(ones,255) into pdm_level and restart both counters.

gpio_o layout:
- [7:0] last_byte
- [15:8] rx_count
- [16] overflow sticky
- [17] framing-error sticky
- [23:18] 0
- [31:24] pdm_level

gpio_i[0]=1 clears both sticky flags each cycle it is high. If a flag-setting event occurs in the same cycle, the set wins.

Simultaneous FIFO push and pop:
- Both take effect in the same cycle.
- Push while full and pop in the same cycle is allowed; the byte is not dropped.

## Timing
- gpio_o is fully registered. last_byte and rx_count update 1 cycle after the mid-stop-bit sample.
- Echo latency: the uart_tx start bit begins ≤4 cycles after the RX mid-stop sample when TX is idle and the FIFO was empty.
- Each TX frame is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames have at most 1 idle cycle between them.
- clk_pdm must have a high and a low phase of ≥1 clk each. In the minimum case (clk_pdm toggling every clk), one edge is detected per 2 clk.
- pdm_level updates 1 cycle after the PDM_WINDOW-th sample.
- Reset mid-frame: TX returns to idle-high immediately; RX abandons the frame, and the partial byte is not counted.

## Test plan
- Reset held 50 ns, then released → uart_tx=1 and gpio_o=0 during and after reset until stimulus.
- Send 0x53 ('S') at 500 ns/bit → gpio_o[7:0]=0x53, gpio_o[15:8]=1. The same 10-bit frame 0x53 appears on uart_tx within 4 cycles of the RX mid-stop sample.
- Send 300 bytes 0x00..0xFF,0x00..0x2B back-to-back → gpio_o[15:8]=0x2C (300 mod 256). uart_tx echoes every byte in order. gpio_o[16]=0, because the TX rate equals the RX rate.
- Hold uart_tx busy with ≥17 queued bytes at 2× RX rate (CLKS_PER_BIT for TX via a test override, or pulse stimulus) → gpio_o[16]=1. Then gpio_i[0]=1 for 1 cycle → gpio_o[16]=0.
- Frame with stop bit 0 → gpio_o[17]=1; rx_count and last_byte unchanged.
- clk_pdm toggling every clk, pdm_input toggling on each clk_pdm rise → after 256 samples gpio_o[31:24]=128 (±1). Constant pdm_input=1 → 255. Constant pdm_input=0 → 0.
